// File: rtl/denise_bitplane_serializer_if.sv
// denise_bitplane_serializer_if: BPLxDAT write bus, mode/scroll/bpu controls (master drives) and bpldata pixel output (slave drives)
interface denise_bitplane_serializer_if;
  logic        hires;
  logic        shres;
  logic [15:0] data_in;
  logic [7:0]  wr_plane;
  logic [3:0]  scroll_odd;
  logic [3:0]  scroll_even;
  logic [3:0]  bpu;
  logic [7:0]  bpldata;
  modport master (output hires, shres, data_in, wr_plane, scroll_odd, scroll_even, bpu, input bpldata);
  modport slave (input hires, shres, data_in, wr_plane, scroll_odd, scroll_even, bpu, output bpldata);
endinterface

// File: rtl/denise_bitplane_serializer.sv
// denise_bitplane_serializer: 8-plane parallel-to-serial bitplane engine; ports clk, reset (sync, active-high), bus (slave: writes, mode, scroll, bpu in; bpldata out)
module denise_bitplane_serializer (
  input logic clk,
  input logic reset,
  denise_bitplane_serializer_if.slave bus
);
  logic [1:0]  phase_q, phase_d;
  logic        pending_q, pending_d;
  logic [15:0] hold_q [8];
  logic [15:0] hold_d [8];
  logic [15:0] shreg_q [8];
  logic [15:0] shreg_d [8];
  logic [15:0] dl_q [8];
  logic [15:0] dl_d [8];
  logic [7:0]  bpldata_q, bpldata_d, s, t;
  logic [3:0]  bpu_eff, sc;
  logic        shift_step, transfer;
  always_comb begin
    shift_step = bus.shres | (bus.hires ? phase_q[0] : &phase_q);
    transfer = shift_step & pending_q & ~bus.wr_plane[0];
    phase_d = phase_q + 2'd1;
    pending_d = bus.wr_plane[0] | (pending_q & ~transfer);
    bpu_eff = bus.bpu > 4'd8 ? 4'd8 : bus.bpu;
    sc = '0;
    s = '0;
    t = '0;
    bpldata_d = '0;
    for (int n = 0; n < 8; n++) begin
      sc = n[0] ? bus.scroll_even : bus.scroll_odd;
      s[n] = shreg_q[n][15];
      t[n] = sc == 4'd0 ? s[n] : dl_q[n][sc - 4'd1];
      hold_d[n] = bus.wr_plane[n] ? bus.data_in : hold_q[n];
      shreg_d[n] = !shift_step ? shreg_q[n] : transfer ? hold_q[n] : {shreg_q[n][14:0], 1'b0};
      dl_d[n] = shift_step ? {dl_q[n][14:0], s[n]} : dl_q[n];
      bpldata_d[n] = (4'(n) < bpu_eff) & t[n];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q <= '0;
      pending_q <= 1'b0;
      bpldata_q <= '0;
      hold_q <= '{default: '0};
      shreg_q <= '{default: '0};
      dl_q <= '{default: '0};
    end else begin
      phase_q <= phase_d;
      pending_q <= pending_d;
      bpldata_q <= bpldata_d;
      hold_q <= hold_d;
      shreg_q <= shreg_d;
      dl_q <= dl_d;
    end
  end
  assign bus.bpldata = bpldata_q;
endmodule

// File: tb/tb_denise_bitplane_serializer.sv
// tb_denise_bitplane_serializer: directed self-checking bench for the bitplane serializer
module tb_denise_bitplane_serializer;
  logic clk;
  logic reset;
  int n_checks;
  int n_fail;
  denise_bitplane_serializer_if bus ();
  denise_bitplane_serializer dut (.clk(clk), .reset(reset), .bus(bus));
  always #5 clk = ~clk;
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset;
    reset = 1'b1;
    tick;
    reset = 1'b0;
  endtask
  task automatic test_reset;
    do_reset;
    n_checks++;
    if (bus.bpldata !== 8'h00) begin
      n_fail++;
      $display("FAIL reset bpldata=%h expected=00", bus.bpldata);
    end
  endtask
  task automatic test_lores;
    logic [7:0] exp;
    bus.hires = 0; bus.shres = 0; bus.bpu = 4'd1;
    do_reset;
    bus.data_in = 16'h8001; bus.wr_plane = 8'h01;
    tick;
    bus.wr_plane = 8'h00;
    for (int i = 2; i <= 72; i++) begin
      tick;
      exp = ((i >= 5 && i <= 8) || (i >= 65 && i <= 68)) ? 8'h01 : 8'h00;
      n_checks++;
      if (bus.bpldata !== exp) begin
        n_fail++;
        $display("FAIL lores cyc=%0d bpldata=%h expected=%h", i, bus.bpldata, exp);
      end
    end
  endtask
  task automatic test_dual_scroll;
    logic [3:0] so [2];
    logic [3:0] se [2];
    int p1 [2];
    int p2 [2];
    logic [7:0] exp;
    so[0] = 4'd0; se[0] = 4'd3; p1[0] = 5; p2[0] = 17;
    so[1] = 4'd1; se[1] = 4'd0; p1[1] = 9; p2[1] = 5;
    for (int c = 0; c < 2; c++) begin
      bus.hires = 0; bus.shres = 0; bus.bpu = 4'd2;
      bus.scroll_odd = so[c]; bus.scroll_even = se[c];
      do_reset;
      bus.data_in = 16'h8000; bus.wr_plane = 8'h02;
      tick;
      bus.wr_plane = 8'h01;
      tick;
      bus.wr_plane = 8'h00;
      for (int i = 3; i <= 40; i++) begin
        tick;
        exp = {6'd0, (i >= p2[c] && i < p2[c] + 4), (i >= p1[c] && i < p1[c] + 4)};
        n_checks++;
        if (bus.bpldata !== exp) begin
          n_fail++;
          $display("FAIL dual_scroll cfg=%0d cyc=%0d bpldata=%h expected=%h", c, i, bus.bpldata, exp);
        end
      end
    end
    bus.scroll_odd = 4'd0; bus.scroll_even = 4'd0;
  endtask
  task automatic test_hires_shres;
    logic [7:0] exp;
    int k;
    bus.hires = 1; bus.shres = 0; bus.bpu = 4'd1;
    do_reset;
    bus.data_in = 16'hAAAA; bus.wr_plane = 8'h01;
    tick;
    bus.wr_plane = 8'h00;
    for (int i = 2; i <= 40; i++) begin
      tick;
      k = (i - 3) / 2;
      exp = (i >= 3 && i <= 34 && k % 2 == 0) ? 8'h01 : 8'h00;
      n_checks++;
      if (bus.bpldata !== exp) begin
        n_fail++;
        $display("FAIL hires cyc=%0d bpldata=%h expected=%h", i, bus.bpldata, exp);
      end
    end
    bus.hires = 0; bus.shres = 1;
    do_reset;
    bus.data_in = 16'hAAAA; bus.wr_plane = 8'h01;
    tick;
    bus.wr_plane = 8'h00;
    for (int i = 2; i <= 24; i++) begin
      tick;
      exp = (i >= 3 && i <= 18 && (i - 3) % 2 == 0) ? 8'h01 : 8'h00;
      n_checks++;
      if (bus.bpldata !== exp) begin
        n_fail++;
        $display("FAIL shres cyc=%0d bpldata=%h expected=%h", i, bus.bpldata, exp);
      end
    end
    bus.shres = 0;
  endtask
  task automatic test_bpu_mask;
    logic [3:0] bv [3];
    logic [7:0] ev [3];
    logic [7:0] exp;
    bv[0] = 4'd5; ev[0] = 8'h1F;
    bv[1] = 4'd11; ev[1] = 8'hFF;
    bv[2] = 4'd0; ev[2] = 8'h00;
    for (int c = 0; c < 3; c++) begin
      bus.hires = 0; bus.shres = 1; bus.bpu = bv[c];
      do_reset;
      bus.data_in = 16'hFFFF; bus.wr_plane = 8'hFF;
      tick;
      bus.wr_plane = 8'h00;
      for (int i = 2; i <= 20; i++) begin
        tick;
        exp = (i >= 3 && i <= 18) ? ev[c] : 8'h00;
        n_checks++;
        if (bus.bpldata !== exp) begin
          n_fail++;
          $display("FAIL bpu_mask bpu=%0d cyc=%0d bpldata=%h expected=%h", bv[c], i, bus.bpldata, exp);
        end
      end
    end
    bus.shres = 0;
  endtask
  task automatic test_simultaneous;
    logic [7:0] exp;
    bus.hires = 0; bus.shres = 0; bus.bpu = 4'd1;
    do_reset;
    tick;
    tick;
    tick;
    bus.data_in = 16'h8000; bus.wr_plane = 8'h01;
    tick;
    bus.wr_plane = 8'h00;
    for (int i = 5; i <= 16; i++) begin
      tick;
      exp = (i >= 9 && i <= 12) ? 8'h01 : 8'h00;
      n_checks++;
      if (bus.bpldata !== exp) begin
        n_fail++;
        $display("FAIL simultaneous cyc=%0d bpldata=%h expected=%h", i, bus.bpldata, exp);
      end
    end
  endtask
  task automatic test_reset_midline;
    logic [7:0] exp;
    bus.hires = 0; bus.shres = 0; bus.bpu = 4'd2;
    do_reset;
    bus.data_in = 16'hFFFF; bus.wr_plane = 8'h03;
    tick;
    bus.wr_plane = 8'h00;
    for (int i = 2; i <= 24; i++) begin
      tick;
      exp = (i >= 5) ? 8'h03 : 8'h00;
      n_checks++;
      if (bus.bpldata !== exp) begin
        n_fail++;
        $display("FAIL midline_pre cyc=%0d bpldata=%h expected=%h", i, bus.bpldata, exp);
      end
    end
    do_reset;
    n_checks++;
    if (bus.bpldata !== 8'h00) begin
      n_fail++;
      $display("FAIL midline_reset bpldata=%h expected=00", bus.bpldata);
    end
    bus.data_in = 16'hFFFF; bus.wr_plane = 8'h01;
    tick;
    bus.wr_plane = 8'h00;
    for (int i = 2; i <= 12; i++) begin
      tick;
      exp = (i >= 5) ? 8'h01 : 8'h00;
      n_checks++;
      if (bus.bpldata !== exp) begin
        n_fail++;
        $display("FAIL midline_post cyc=%0d bpldata=%h expected=%h", i, bus.bpldata, exp);
      end
    end
  endtask
  initial begin
    clk = 0; reset = 1;
    bus.hires = 0; bus.shres = 0; bus.data_in = '0; bus.wr_plane = '0;
    bus.scroll_odd = '0; bus.scroll_even = '0; bus.bpu = '0;
    n_checks = 0; n_fail = 0;
    test_reset;
    test_lores;
    test_dual_scroll;
    test_hires_shres;
    test_bpu_mask;
    test_simultaneous;
    test_reset_midline;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/denise_bitplane_serializer.md
Name: denise_bitplane_serializer

Overview:
- Bitplane parallel-to-serial engine in Denise; generates the raw per-pixel bitplane vector `bpldata[8:1]` that the playfield engine consumes.
- Accepts 16-bit BPLxDAT writes into holding registers. A write to plane 1 arms a parallel transfer into per-plane shift registers.
- Shifts at the lores, hires or shres pixel rate.
- Applies independent odd-plane and even-plane horizontal scroll delays, and masks planes beyond the active plane count.

Parameters:
- None.

Ports:
- `clk`  in  1  system clock; one clk = one shres pixel.
- `reset`  in  1  synchronous, active-high reset.
- `hires`  in  1  hires mode: shift every 2 clk.
- `shres`  in  1  superhires mode: shift every clk; overrides `hires`.
- `data_in`  in  16  BPLxDAT write data.
- `wr_plane`  in  8  one-hot write strobes; bit n-1 writes the plane n holding register.
- `scroll_odd`  in  4  delay in shift steps for planes 1,3,5,7.
- `scroll_even`  in  4  delay in shift steps for planes 2,4,6,8.
- `bpu`  in  4  active plane count 0..8; values above 8 are treated as 8.
- `bpldata`  out  8  serialized bitplane pixel; bit n = plane n.

Behaviour:
- Clocking: one clock, `clk`. Reset is synchronous and active-high on `reset`; polarity and synchronicity are fixed.
- Reset: holding regs, shift regs and delay lines = 0; pending flag = 0; phase counter = 0; `bpldata` = 0.
- Phase counter:
  - 2-bit, free-running, increments every clk.
  - `shift_step` = 1 every clk if `shres`.
  - Else if `hires`: `shift_step` = 1 when phase[0] = 1.
  - Else (lores): `shift_step` = 1 when phase = 3.
  - Mode changes take effect on the next clk; the phase counter is not reset.
- Holding regs:
  - On any clk with `wr_plane[n-1]` = 1, hold[n] <= `data_in`.
  - Multiple strobes in one clk write the same data to every selected plane.
- Pending flag:
  - Set on the clk where `wr_plane[0]` = 1.
  - Cleared on the shift step that performs the transfer.
  - If `wr_plane[0]` and `shift_step` occur in the same clk, the transfer happens at the next shift step, not this one; pending ends up set.
  - Writes to planes 2-8 while pending is set are included in the transfer.
  - A further plane-1 write while pending is set only updates hold[1]; there is still one transfer.
- Shift regs, on a `shift_step` clk:
  - If pending: shreg[n] <= hold[n] for all 8 planes.
  - Otherwise: shreg[n] <= {shreg[n][14:0], 0}.
  - No change on non-shift clks.
  - After 16 shift steps without a transfer, the output is 0 (transparent).
- Serial bit: s[n] = shreg[n][15].
- Delay lines (16 bits per plane):
  - On a `shift_step` clk, dl[n] <= {dl[n][14:0], s[n]}, where s[n] is the pre-update value.
  - Tap t[n] = s[n] if the scroll value is 0, else dl[n][scroll-1].
  - The scroll value is `scroll_odd` for odd n and `scroll_even` for even n.
  - Scroll is sampled live every clk; a mid-line change takes effect on the next clk.
- Output register:
  - Every clk, `bpldata[n]` <= t[n] if n ≤ min(`bpu`,8), else 0.
  - `bpu` = 0 forces all zeros.
- Latency, scroll 0: first pixel (hold[n][15]) appears on `bpldata` 1 clk after the transfer shift-step clk. Each subsequent bit appears 1 clk after each following shift step.
- Latency, scroll k: the same pixel appears exactly k shift steps later.
- Reset mid-operation: everything clears on that clk; `bpldata` = 0 on the next clk; any pending transfer is lost.

Test Plan:
- Lores, scroll 0, `bpu`=1, write plane1=16'h8001 -> `bpldata[1]`=1 for 4 clk, then 0 for 56 clk, then 1 for 4 clk, then 0.
- Dual scroll: `bpu`=2, hold[2]=16'h8000, then plane1=16'h8000, `scroll_odd`=0, `scroll_even`=3, lores -> `bpldata[1]` pulses first; `bpldata[2]` pulses exactly 12 clk later.
- Hires then shres: plane1=16'hAAAA -> `bpldata[1]` toggles every 2 clk (hires) and every 1 clk (shres), 16 pixels each, then 0.
- `bpu` mask: all 8 planes written 16'hFFFF, `bpu`=5 -> `bpldata` = 8'h1F for 16 shift steps; `bpu`=11 -> 8'hFF.
- Simultaneous write/shift: `wr_plane[0]` asserted on a shift_step clk -> no transfer that step; data appears 1 clk after the next shift step.
- Reset mid-line: `reset` asserted after 5 pixels of 16'hFFFF -> `bpldata`=0 from the next clk; a later plane-1 write with no plane-2 write loads hold[2]=0.
